// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: FSM encoding, data_input field positions and key indices shared by the loader
package instr_loader_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam int OPC_LSB    = 0;
  localparam int OPC_W      = 5;
  localparam int IMMS_BIT   = 7;
  localparam int REGEN_BIT  = 8;
  localparam int REGRST_BIT = 9;
  localparam int RDEST_LSB  = 6;
  localparam int RSRC_LSB   = 0;
  localparam int REG_W      = 4;
  localparam int IMM_SHIFT  = 6;
  localparam int KEY_REG    = 0;
  localparam int KEY_SETUP  = 1;
  localparam int KEY_IMM    = 2;
  localparam int KEY_CLK    = 3;
  function automatic logic step_ok(input logic setup_v, input logic reg_v, input logic imm_s, input logic imm_v);
    return setup_v & reg_v & (~imm_s | imm_v);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, debounce counter and single-cycle press event for an active-low key
module key_debounce
  import instr_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [1:0] boot;
  logic armed;
  logic [CW-1:0] cnt;
  logic done;
  assign done = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  // Accept a new level after it has held for DEBOUNCE_CYCLES clocks; presses only fire once the key was seen released after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      boot  <= 2'b00;
      armed <= 1'b0;
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      boot  <= {boot[0], 1'b1};
      armed <= armed | (boot[1] & sync[1]);
      cnt   <= (sync[1] == level || done) ? '0 : cnt + CW'(1);
      level <= done ? sync[1] : level;
      press <= done & ~sync[1] & armed;
    end
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: key-driven instruction field loader with single-step enable; LOADER_AUTOINC_EN adds RdestLoc auto-increment after each step
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_CNT_W      = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [9:0]            data_input,
  input  logic                  ld_Reg,
  input  logic                  ld_Setup,
  input  logic                  ld_Imm,
  input  logic                  ld_clk,
  output logic [3:0]            RdestLoc,
  output logic [3:0]            RsrcLoc,
  output logic [4:0]            OpCode,
  output logic [15:0]           Imm,
  output logic                  Imm_s,
  output logic                  RegEn,
  output logic                  RegRst,
  output logic                  StepEn,
  output logic                  Err,
  output logic [STEP_CNT_W-1:0] StepCount
);
  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] press;
  logic [2:0] unused_level;
  logic [9:0] d1;
  logic [9:0] d;
  logic [1:0] state;
  logic setup_v;
  logic imm_v;
  logic reg_v;
  logic cap;
  logic ok;
  assign raw          = {ld_clk, ld_Imm, ld_Setup, ld_Reg};
  assign unused_level = level[2:0];
  assign cap          = state != STEP;
  assign ok           = step_ok(setup_v, reg_v, Imm_s, imm_v);
  assign StepEn       = state == STEP;
  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk  (Clk),
      .rst_n(Rst),
      .key  (raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end
  // Synchronize the switch word; it is only sampled long after it settles, on a debounced press
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      d1 <= '0;
      d  <= '0;
    end else begin
      d1 <= data_input;
      d  <= d1;
    end
  end
  // Step sequencer: validity check on ld_clk press, one-cycle STEP, then wait for key release
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      Err       <= 1'b0;
      StepCount <= '0;
    end else begin
      state     <= state == IDLE ? ((press[KEY_CLK] && ok) ? STEP : IDLE) :
                   state == STEP ? HOLD : (level[KEY_CLK] ? IDLE : HOLD);
      Err       <= state == IDLE && press[KEY_CLK] && !ok;
      StepCount <= StepEn ? StepCount + STEP_CNT_W'(1) : StepCount;
    end
  end
  // Field capture; presses landing in the STEP cycle are dropped so fields hold still under StepEn
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      OpCode   <= '0;
      Imm_s    <= 1'b0;
      RegEn    <= 1'b0;
      RegRst   <= 1'b0;
      Imm      <= '0;
      RdestLoc <= '0;
      RsrcLoc  <= '0;
      setup_v  <= 1'b0;
      imm_v    <= 1'b0;
      reg_v    <= 1'b0;
    end else begin
      if (cap && press[KEY_SETUP]) begin
        OpCode  <= d[OPC_LSB +: OPC_W];
        Imm_s   <= d[IMMS_BIT];
        RegEn   <= d[REGEN_BIT];
        RegRst  <= d[REGRST_BIT];
        setup_v <= 1'b1;
      end
      if (cap && press[KEY_IMM]) begin
        Imm   <= 16'(d) << IMM_SHIFT;
        imm_v <= 1'b1;
      end
      if (cap && press[KEY_REG]) begin
        RdestLoc <= d[RDEST_LSB +: REG_W];
        RsrcLoc  <= d[RSRC_LSB +: REG_W];
        reg_v    <= 1'b1;
      end
`ifdef LOADER_AUTOINC_EN
      else if (StepEn) begin
        RdestLoc <= RdestLoc + 4'd1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed scenarios checked every cycle against a behavioural model plus literal expectations
module tb_instr_loader;
  localparam int N = 4;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [9:0] data_input = '0;
  logic [3:0] keys = 4'hF;
  logic [3:0] RdestLoc, RsrcLoc;
  logic [4:0] OpCode;
  logic [15:0] Imm;
  logic Imm_s, RegEn, RegRst, StepEn, Err;
  logic [7:0] StepCount;
  int checks = 0;
  int errors = 0;
  int n_step = 0;
  int n_err = 0;
  int s, e;

  always #5 Clk = ~Clk;

  instr_loader #(.DEBOUNCE_CYCLES(N), .STEP_CNT_W(8)) u_dut (
    .Clk(Clk), .Rst(Rst), .data_input(data_input),
    .ld_Reg(keys[0]), .ld_Setup(keys[1]), .ld_Imm(keys[2]), .ld_clk(keys[3]),
    .RdestLoc(RdestLoc), .RsrcLoc(RsrcLoc), .OpCode(OpCode), .Imm(Imm),
    .Imm_s(Imm_s), .RegEn(RegEn), .RegRst(RegRst), .StepEn(StepEn), .Err(Err),
    .StepCount(StepCount)
  );

  // Behavioural model: a key level is accepted once the raw key has held a new value for N+2 samples
  // (2 synchronizer clocks plus N stable clocks); a press fires on acceptance of 0 if the key was seen released since reset.
  logic [3:0] m_last, m_lvl, m_ev, m_arm;
  int m_run [4];
  logic [3:0] m_rd, m_rs;
  logic [4:0] m_op;
  logic [15:0] m_imm;
  logic m_imms, m_regen, m_regrst, m_step, m_err, m_busy, m_sv, m_iv, m_rv;
  logic [7:0] m_cnt;
  logic m_ok;
  assign m_ok = m_sv & m_rv & (!m_imms | m_iv);

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_last <= '1; m_lvl <= '1; m_ev <= '0; m_arm <= '0;
      for (int k = 0; k < 4; k++) m_run[k] <= 0;
      m_rd <= '0; m_rs <= '0; m_op <= '0; m_imm <= '0;
      m_imms <= 0; m_regen <= 0; m_regrst <= 0; m_step <= 0; m_err <= 0;
      m_busy <= 0; m_sv <= 0; m_iv <= 0; m_rv <= 0; m_cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        m_last[k] <= keys[k];
        m_run[k] <= (keys[k] != m_last[k]) ? 1 : (m_run[k] < 1000 ? m_run[k] + 1 : m_run[k]);
        if (keys[k] == m_last[k] && m_run[k] == N + 1 && keys[k] != m_lvl[k]) m_lvl[k] <= keys[k];
        m_ev[k] <= keys[k] == m_last[k] && m_run[k] == N + 1 && keys[k] != m_lvl[k] && !keys[k] && m_arm[k];
        if (keys[k]) m_arm[k] <= 1'b1;
      end
      m_step <= 1'b0;
      m_err <= 1'b0;
      if (m_ev[3] && !m_busy) begin
        if (m_ok) begin m_step <= 1'b1; m_busy <= 1'b1; end
        else m_err <= 1'b1;
      end
      if (m_busy && !m_step && m_lvl[3]) m_busy <= 1'b0;
      if (m_step) m_cnt <= m_cnt + 8'd1;
      if (!m_step && m_ev[1]) begin
        m_op <= data_input[4:0]; m_imms <= data_input[7]; m_regen <= data_input[8];
        m_regrst <= data_input[9]; m_sv <= 1'b1;
      end
      if (!m_step && m_ev[2]) begin m_imm <= {data_input, 6'b0}; m_iv <= 1'b1; end
      if (!m_step && m_ev[0]) begin m_rd <= data_input[9:6]; m_rs <= data_input[3:0]; m_rv <= 1'b1; end
`ifdef LOADER_AUTOINC_EN
      if (m_step) m_rd <= m_rd + 4'd1;
`endif
    end
  end

  always @(posedge Clk) begin
    if (StepEn) n_step <= n_step + 1;
    if (Err) n_err <= n_err + 1;
  end

  logic [41:0] dut_vec, mod_vec;
  assign dut_vec = {RdestLoc, RsrcLoc, OpCode, Imm, Imm_s, RegEn, RegRst, StepEn, Err, StepCount};
  assign mod_vec = {m_rd, m_rs, m_op, m_imm, m_imms, m_regen, m_regrst, m_step, m_err, m_cnt};

  always @(negedge Clk) begin
    checks++;
    if (dut_vec !== mod_vec) begin
      errors++;
      $display("FAIL model t=%0t: dut=%h model=%h", $time, dut_vec, mod_vec);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic tap(input int k);
    keys[k] = 1'b0;
    tick(8);
    keys[k] = 1'b1;
    tick(8);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #1 Rst = 1'b0;
    tick(2);
    chk("reset outputs", 64'(dut_vec), 64'd0);
    @(negedge Clk); #2 Rst = 1'b1;
    tick(4);
    data_input = 10'h105; tick(1); tap(1);
    data_input = 10'h0C2; tick(1); tap(0);
    s = n_step; tap(3);
    chk("opcode", 64'(OpCode), 64'h05);
    chk("regen", 64'(RegEn), 64'd1);
    chk("rsrc", 64'(RsrcLoc), 64'd2);
`ifdef LOADER_AUTOINC_EN
    chk("rdest", 64'(RdestLoc), 64'd4);
`else
    chk("rdest", 64'(RdestLoc), 64'd3);
`endif
    chk("one step pulse", 64'(n_step - s), 64'd1);
    chk("count 1", 64'(StepCount), 64'd1);
    data_input = 10'h185; tap(1);
    s = n_step; e = n_err; tap(3);
    chk("imm_s set", 64'(Imm_s), 64'd1);
    chk("reject err", 64'(n_err - e), 64'd1);
    chk("reject no step", 64'(n_step - s), 64'd0);
    chk("reject count", 64'(StepCount), 64'd1);
    data_input = 10'h3FF; tap(2);
    chk("imm value", 64'(Imm), 64'hFFC0);
    s = n_step; tap(3);
    chk("imm step", 64'(n_step - s), 64'd1);
    chk("count 2", 64'(StepCount), 64'd2);
    s = n_step; keys[3] = 1'b0; tick(100);
    chk("held single pulse", 64'(n_step - s), 64'd1);
    chk("held state hold", 64'(u_dut.state), 64'd2);
    keys[3] = 1'b1; tick(10);
    chk("released idle", 64'(u_dut.state), 64'd0);
    s = n_step; e = n_err;
    tick(3); keys[3] = 1'b0; tick(3); keys[3] = 1'b1; tick(3); keys[3] = 1'b0; tick(3);
    chk("bounce no event", 64'(n_step - s), 64'd0);
    tick(10);
    chk("bounce one event", 64'(n_step - s), 64'd1);
    chk("bounce no err", 64'(n_err - e), 64'd0);
    keys[3] = 1'b1; tick(10);
    chk("count 4", 64'(StepCount), 64'd4);
    repeat (252) tap(3);
    chk("count wrap", 64'(StepCount), 64'd0);
    data_input = 10'h3C0; tap(0);
    chk("rdest 15", 64'(RdestLoc), 64'd15);
    tap(3);
`ifdef LOADER_AUTOINC_EN
    chk("rdest wrap", 64'(RdestLoc), 64'd0);
`else
    chk("rdest stable", 64'(RdestLoc), 64'd15);
`endif
    keys[3] = 1'b0; tick(10);
    chk("hold before reset", 64'(u_dut.state), 64'd2);
    @(negedge Clk); #2 Rst = 1'b0;
    #1 chk("reset mid hold", 64'(dut_vec), 64'd0);
    s = n_step; e = n_err;
    tick(3); #2 Rst = 1'b1;
    tick(20);
    chk("no step on release", 64'(n_step - s), 64'd0);
    chk("no err on release", 64'(n_err - e), 64'd0);
    chk("outputs after reset", 64'(dut_vec), 64'd0);
    keys[3] = 1'b1; tick(10);
    e = n_err; s = n_step; tap(3);
    chk("valid cleared err", 64'(n_err - e), 64'd1);
    chk("valid cleared no step", 64'(n_step - s), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
